// File: rtl/syn_current_gen_if.sv
// Bundle of the synaptic-current block's enable, spike/weight inputs and
// current/status outputs. The master side drives spikes and the slave
// (the current generator) drives the current and status.
interface syn_current_gen_if;
  logic              en;
  logic              spike_exc;
  logic [7:0]        w_exc;
  logic              spike_inh;
  logic [7:0]        w_inh;
  logic signed [7:0] I_syn;
  logic              active;
  logic [7:0]        evt_cnt;

  modport master (
    output en, spike_exc, w_exc, spike_inh, w_inh,
    input  I_syn, active, evt_cnt
  );

  modport slave (
    input  en, spike_exc, w_exc, spike_inh, w_inh,
    output I_syn, active, evt_cnt
  );
endinterface

// File: rtl/syn_current_gen.sv
// Synaptic current generator: accumulates excitatory/inhibitory weighted
// spikes into a saturating signed 8-bit current that decays geometrically
// towards zero once every DECAY_PERIOD enabled cycles.
module syn_current_gen #(
  parameter int DECAY_SHIFT  = 2,
  parameter int DECAY_PERIOD = 4
) (
  input logic              clk,
  input logic              rst_n,
  syn_current_gen_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(DECAY_PERIOD - 1);

  logic signed [7:0] r_isyn;
  logic [7:0]        r_cnt;
  logic [7:0]        r_evt;

  logic              w_tick;
  logic signed [7:0] w_shr;
  logic signed [7:0] w_d;
  logic signed [9:0] w_sum;
  logic [1:0]        w_nspk;
  logic [8:0]        w_evt_sum;

  // Clamp the 10-bit sum into the signed 8-bit current range.
  function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127)
      return 8'sd127;
    else if (v < -10'sd128)
      return -8'sd128;
    else
      return v[7:0];
  endfunction

  // Clamp the event counter sum at 255.
  function automatic logic [7:0] sat_evt(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  assign w_tick = bus.en && (r_cnt == CNT_LAST);
  assign w_shr  = r_isyn >>> DECAY_SHIFT;

  // Decay step: small positive values are forced to shrink by 1 so they
  // reach zero; negative values converge naturally via -1 >>> S = -1.
  always_comb begin
    w_d = 8'sd0;
    if (w_tick) begin
      if ((r_isyn > 8'sd0) && (w_shr == 8'sd0))
        w_d = 8'sd1;
      else
        w_d = w_shr;
    end
  end

  // Next-current sum at 10 bits so no intermediate can wrap.
  always_comb begin
    w_sum = {{2{r_isyn[7]}}, r_isyn}
          - {{2{w_d[7]}}, w_d}
          + {2'b00, (bus.spike_exc ? bus.w_exc : 8'h00)}
          - {2'b00, (bus.spike_inh ? bus.w_inh : 8'h00)};
  end

  assign w_nspk    = {1'b0, bus.spike_exc} + {1'b0, bus.spike_inh};
  assign w_evt_sum = {1'b0, r_evt} + {7'b0, w_nspk};

  // Current, decay phase and event count advance only on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isyn <= 8'sd0;
      r_cnt  <= 8'd0;
      r_evt  <= 8'd0;
    end else if (bus.en) begin
      r_isyn <= sat8(w_sum);
      r_cnt  <= (r_cnt == CNT_LAST) ? 8'd0 : r_cnt + 8'd1;
      r_evt  <= sat_evt(w_evt_sum);
    end
  end

  assign bus.I_syn   = r_isyn;
  assign bus.active  = (r_isyn != 8'sd0);
  assign bus.evt_cnt = r_evt;

endmodule

// File: tb/tb_syn_current_gen.sv
// Directed bench for syn_current_gen: decay profile, saturation, dual spikes
// on a decay tick, enable gaps, negative decay and event-count saturation
// with asynchronous reset.
module tb_syn_current_gen;

  logic clk;
  logic rst_n;

  syn_current_gen_if bus  ();
  syn_current_gen_if bus3 ();

  syn_current_gen #(.DECAY_SHIFT(2), .DECAY_PERIOD(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  syn_current_gen #(.DECAY_SHIFT(3), .DECAY_PERIOD(4)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ph  = 0;
  int ph3 = 0;
  bit tick  = 1'b0;
  bit tick3 = 1'b0;

  int exp25 [18] = '{100, 75, 57, 43, 33, 25, 19, 15, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};
  int exp29 [6]  = '{-5, -4, -3, -2, -1, 0};

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge; the bench tracks the expected decay phase itself.
  task automatic step();
    @(posedge clk);
    tick  = bus.en  && (ph  == 3);
    tick3 = bus3.en && (ph3 == 3);
    if (bus.en)  ph  = (ph  == 3) ? 0 : ph  + 1;
    if (bus3.en) ph3 = (ph3 == 3) ? 0 : ph3 + 1;
    #1;
  endtask

  initial begin
    int idx;
    rst_n = 1'b0;
    bus.en = 1'b0;  bus.spike_exc = 1'b0;  bus.w_exc = 8'd0;
    bus.spike_inh = 1'b0;  bus.w_inh = 8'd0;
    bus3.en = 1'b0; bus3.spike_exc = 1'b0; bus3.w_exc = 8'd0;
    bus3.spike_inh = 1'b0; bus3.w_inh = 8'd0;

    #22;
    chk("rst_isyn",   int'(bus.I_syn), 0);
    chk("rst_active", int'(bus.active), 0);
    chk("rst_evt",    int'(bus.evt_cnt), 0);
    rst_n = 1'b1;
    ph = 0; ph3 = 0;

    // single excitatory spike and its decay profile
    bus.en = 1'b1;
    bus.spike_exc = 1'b1; bus.w_exc = 8'd100;
    step();
    bus.spike_exc = 1'b0; bus.w_exc = 8'd0;
    chk("exc_isyn",   int'(bus.I_syn), 100);
    chk("exc_active", int'(bus.active), 1);
    chk("exc_evt",    int'(bus.evt_cnt), 1);
    idx = 0;
    for (int i = 0; i < 76; i++) begin
      step();
      if (tick && idx < 17) idx++;
      chk("decay_isyn",   int'(bus.I_syn), exp25[idx]);
      chk("decay_active", int'(bus.active), (exp25[idx] != 0) ? 1 : 0);
    end

    // positive and negative saturation on non-tick edges
    while (ph != 0) step();
    bus.spike_exc = 1'b1; bus.w_exc = 8'd120;
    step();
    chk("sat_pre", int'(bus.I_syn), 120);
    bus.w_exc = 8'd100;
    step();
    chk("sat_pos", int'(bus.I_syn), 127);
    bus.spike_exc = 1'b0; bus.w_exc = 8'd0;
    bus.spike_inh = 1'b1; bus.w_inh = 8'd255;
    step();
    chk("sat_neg", int'(bus.I_syn), -128);
    chk("sat_evt", int'(bus.evt_cnt), 4);
    bus.spike_inh = 1'b0; bus.w_inh = 8'd0;

    // asynchronous reset pulse, checked with no clock edge in between
    #2 rst_n = 1'b0;
    #1;
    chk("arst_isyn",   int'(bus.I_syn), 0);
    chk("arst_active", int'(bus.active), 0);
    chk("arst_evt",    int'(bus.evt_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ph = 0; ph3 = 0;

    // both spikes together on a decay tick
    bus.spike_exc = 1'b1; bus.w_exc = 8'd100;
    step();
    bus.spike_exc = 1'b0; bus.w_exc = 8'd0;
    step();
    step();
    chk("dual_pre", int'(bus.I_syn), 100);
    bus.spike_exc = 1'b1; bus.w_exc = 8'd50;
    bus.spike_inh = 1'b1; bus.w_inh = 8'd20;
    step();
    chk("dual_tick",  int'(tick), 1);
    chk("dual_isyn",  int'(bus.I_syn), 105);
    chk("dual_evt",   int'(bus.evt_cnt), 3);
    bus.spike_exc = 1'b0; bus.w_exc = 8'd0;
    bus.spike_inh = 1'b0; bus.w_inh = 8'd0;

    // enable gap: state and decay phase freeze, spikes dropped
    step();
    step();
    chk("gap_pre", int'(bus.I_syn), 105);
    bus.en = 1'b0;
    bus.w_exc = 8'd77; bus.w_inh = 8'd77;
    for (int i = 0; i < 10; i++) begin
      bus.spike_exc = i[0];
      bus.spike_inh = ~i[0];
      step();
      chk("gap_isyn", int'(bus.I_syn), 105);
      chk("gap_evt",  int'(bus.evt_cnt), 3);
    end
    bus.spike_exc = 1'b0; bus.spike_inh = 1'b0;
    bus.w_exc = 8'd0; bus.w_inh = 8'd0;
    bus.en = 1'b1;
    step();
    chk("gap_hold", int'(bus.I_syn), 105);
    step();
    chk("gap_tick", int'(bus.I_syn), 79);

    // zero-weight spikes count as events but leave the current alone
    bus.spike_exc = 1'b1; bus.spike_inh = 1'b1;
    step();
    chk("w0_isyn", int'(bus.I_syn), 79);
    chk("w0_evt",  int'(bus.evt_cnt), 5);
    bus.spike_exc = 1'b0; bus.spike_inh = 1'b0;

    // negative current decaying to zero (shift-3 instance)
    bus3.en = 1'b1;
    bus3.spike_inh = 1'b1; bus3.w_inh = 8'd5;
    step();
    bus3.spike_inh = 1'b0; bus3.w_inh = 8'd0;
    chk("neg_start", int'(bus3.I_syn), -5);
    idx = 0;
    for (int i = 0; i < 28; i++) begin
      step();
      if (tick3 && idx < 5) idx++;
      chk("neg_decay", int'(bus3.I_syn), exp29[idx]);
    end

    // event counter saturation then asynchronous reset mid-stream
    bus.spike_exc = 1'b1; bus.w_exc = 8'd0;
    for (int i = 0; i < 300; i++) begin
      step();
      chk("evt_sat", int'(bus.evt_cnt), (5 + i + 1 > 255) ? 255 : 5 + i + 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("end_rst_isyn",   int'(bus.I_syn), 0);
    chk("end_rst_active", int'(bus.active), 0);
    chk("end_rst_evt",    int'(bus.evt_cnt), 0);
    chk("end_rst_isyn3",  int'(bus3.I_syn), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
